// File: rtl/prbs4_pkg.sv
// ============================================================
// prbs4_pkg - shared types and next-bit function for the 4-bit LFSR pattern
// Rev 1.0
// ============================================================
`default_nettype none

package prbs4_pkg;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] SEED = 4'b1111;

    function automatic logic prbs4_next_bit(input logic [3:0] h);
        return h[1] ^ h[3];
    endfunction

endpackage

`default_nettype wire

// File: rtl/prbs4_predictor.sv
// ============================================================
// prbs4_predictor - received-bit history and next-bit prediction
// Rev 1.0
// ============================================================
`default_nettype none

module prbs4_predictor
    import prbs4_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic valid_i,
    input  logic bit_i,
    output logic match,
    output logic hist_zero
);

    logic [3:0] sr;

    // Raw bits always enter the history, so a corrupted history flushes itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= 4'b0000;
        end else if (valid_i) begin
            sr <= {sr[2:0], bit_i};
        end
    end

    assign hist_zero = (sr == 4'b0000);
    assign match     = (bit_i == prbs4_next_bit(sr));

endmodule

`default_nettype wire

// File: rtl/prbs4_checker.sv
// ============================================================
// prbs4_checker - self-synchronising BER checker for the 4-bit LFSR stream
// Rev 1.0
// ============================================================
`default_nettype none

module prbs4_checker
    import prbs4_pkg::*;
#(
    parameter int unsigned LOCK_CNT = 8,
    parameter int unsigned LOSS_CNT = 3,
    parameter int unsigned ERR_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_i,
    input  logic             bit_i,
    input  logic             clr_i,
    output logic             locked_o,
    output logic             err_o,
    output logic [ERR_W-1:0] err_cnt_o
);

    state_t           state, state_nxt;
    logic [1:0]       fill_cnt, fill_nxt;
    logic [7:0]       good_cnt, good_nxt;
    logic [7:0]       bad_cnt, bad_nxt;
    logic             err_nxt;
    logic [ERR_W-1:0] cnt_nxt;
    logic             match, hist_zero, good_bit;
    logic [8:0]       good_inc, bad_inc;

    prbs4_predictor u_pred (
        .clk       (clk),
        .reset     (reset),
        .valid_i   (valid_i),
        .bit_i     (bit_i),
        .match     (match),
        .hist_zero (hist_zero)
    );

    // An all-zero history is never trusted, so a dead line cannot lock.
    assign good_bit = match && !hist_zero;
    assign good_inc = {1'b0, good_cnt} + 9'd1;
    assign bad_inc  = {1'b0, bad_cnt} + 9'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_FILL;
            fill_cnt  <= 2'd0;
            good_cnt  <= 8'd0;
            bad_cnt   <= 8'd0;
            locked_o  <= 1'b0;
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            state     <= state_nxt;
            fill_cnt  <= fill_nxt;
            good_cnt  <= good_nxt;
            bad_cnt   <= bad_nxt;
            locked_o  <= (state_nxt == ST_LOCKED);
            err_o     <= err_nxt;
            err_cnt_o <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fill_nxt  = fill_cnt;
        good_nxt  = good_cnt;
        bad_nxt   = bad_cnt;
        err_nxt   = 1'b0;
        cnt_nxt   = err_cnt_o;
        if (valid_i) begin
            case (state)
                ST_FILL: begin
                    fill_nxt = fill_cnt + 2'd1;
                    if (fill_cnt == 2'd3) begin
                        state_nxt = ST_HUNT;
                        fill_nxt  = 2'd0;
                        good_nxt  = 8'd0;
                    end
                end
                ST_HUNT: begin
                    if (good_bit) begin
                        good_nxt = good_inc[7:0];
                        if (good_inc == 9'(LOCK_CNT)) begin
                            state_nxt = ST_LOCKED;
                            good_nxt  = 8'd0;
                            bad_nxt   = 8'd0;
                        end
                    end else begin
                        good_nxt = 8'd0;
                    end
                end
                ST_LOCKED: begin
                    if (good_bit) begin
                        bad_nxt = 8'd0;
                    end else begin
                        err_nxt = 1'b1;
                        bad_nxt = bad_inc[7:0];
                        if (err_cnt_o != {ERR_W{1'b1}}) begin
                            cnt_nxt = err_cnt_o + 1'b1;
                        end
                        if (bad_inc == 9'(LOSS_CNT)) begin
                            state_nxt = ST_FILL;
                            fill_nxt  = 2'd0;
                            good_nxt  = 8'd0;
                            bad_nxt   = 8'd0;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_FILL;
                    fill_nxt  = 2'd0;
                    good_nxt  = 8'd0;
                    bad_nxt   = 8'd0;
                end
            endcase
        end
        // A clear wins over an error counted on the same edge.
        if (clr_i) begin
            cnt_nxt = '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_prbs4_checker.sv
// ============================================================
// tb_prbs4_checker - scoreboard bench for prbs4_checker (ERR_W 16 and 2)
// Rev 1.0
// ============================================================
`default_nettype none

module tb_prbs4_checker;
    import prbs4_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid = 1'b0;
    logic        bitv = 1'b0;
    logic        clr = 1'b0;
    logic        locked, err, locked2, err2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    prbs4_checker #(.LOCK_CNT(8), .LOSS_CNT(3), .ERR_W(16)) dut (
        .clk(clk), .reset(reset), .valid_i(valid), .bit_i(bitv), .clr_i(clr),
        .locked_o(locked), .err_o(err), .err_cnt_o(cnt)
    );

    prbs4_checker #(.LOCK_CNT(8), .LOSS_CNT(3), .ERR_W(2)) dut2 (
        .clk(clk), .reset(reset), .valid_i(valid), .bit_i(bitv), .clr_i(clr),
        .locked_o(locked2), .err_o(err2), .err_cnt_o(cnt2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic l;
        logic e;
        int   c16;
        int   c2;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    logic [3:0] g;
    int         m_state, m_fill, m_good, m_bad, m_errs;
    logic [3:0] mh;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, expv, $time);
        end
    endtask

    // Reference: 0 = fill, 1 = hunt, 2 = locked
    task automatic model_step(input logic r, input logic v, input logic b, input logic c);
        exp_t x;
        logic e;
        logic ok;
        e = 1'b0;
        if (r) begin
            m_state = 0; m_fill = 0; m_good = 0; m_bad = 0; m_errs = 0; mh = 4'b0000;
        end else begin
            if (v) begin
                ok = (b == (mh[1] ^ mh[3])) && (mh != 4'b0000);
                if (m_state == 0) begin
                    m_fill++;
                    if (m_fill == 4) begin m_state = 1; m_fill = 0; m_good = 0; end
                end else if (m_state == 1) begin
                    m_good = ok ? m_good + 1 : 0;
                    if (m_good == 8) begin m_state = 2; m_good = 0; m_bad = 0; end
                end else begin
                    if (ok) m_bad = 0;
                    else begin
                        e = 1'b1; m_errs++; m_bad++;
                        if (m_bad == 3) begin m_state = 0; m_bad = 0; m_fill = 0; end
                    end
                end
                mh = {mh[2:0], b};
            end
            if (c) m_errs = 0;
        end
        x.l   = (m_state == 2);
        x.e   = e;
        x.c16 = (m_errs > 65535) ? 65535 : m_errs;
        x.c2  = (m_errs > 3) ? 3 : m_errs;
        q.push_back(x);
    endtask

    task automatic step(input logic r, input logic v, input logic b, input logic c);
        @(negedge clk);
        reset = r; valid = v; bitv = b; clr = c;
        model_step(r, v, b, c);
    endtask

    task automatic gen_bit(output logic b);
        b = prbs4_next_bit(g);
        g = {g[2:0], b};
    endtask

    task automatic good(input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            gen_bit(b);
            step(1'b0, 1'b1, b, 1'b0);
        end
    endtask

    task automatic forced();
        step(1'b0, 1'b1, ~(mh[1] ^ mh[3]), 1'b0);
    endtask

    task automatic do_reset();
        g = SEED;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every registered cycle is compared against the scoreboard
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk("sb_locked", {31'd0, locked}, {31'd0, x.l});
                chk("sb_err", {31'd0, err}, {31'd0, x.e});
                chk("sb_cnt16", {16'd0, cnt}, x.c16);
                chk("sb_cnt2", {30'd0, cnt2}, x.c2);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic b;
        g = SEED;
        mh = 4'b0000;
        m_state = 0; m_fill = 0; m_good = 0; m_bad = 0; m_errs = 0;

        do_reset();
        settle();
        chk("rst_locked", {31'd0, locked}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_cnt", {16'd0, cnt}, 0);

        // Clean stream: lock exactly on the 12th valid bit
        good(11);
        settle();
        chk("lock_after_11", {31'd0, locked}, 0);
        good(1);
        settle();
        chk("lock_after_12", {31'd0, locked}, 1);
        good(988);
        settle();
        chk("clean_1000_cnt", {16'd0, cnt}, 0);
        chk("clean_1000_locked", {31'd0, locked}, 1);

        // Single flipped bit: errors on it and on the two bits that tap it
        gen_bit(b);
        step(1'b0, 1'b1, ~b, 1'b0);
        settle();
        chk("flip_err", {31'd0, err}, 1);
        chk("flip_cnt", {16'd0, cnt}, 1);
        good(4);
        settle();
        chk("flip_cnt_after4", {16'd0, cnt}, 3);
        chk("flip_still_locked", {31'd0, locked}, 1);
        good(10);

        // Three consecutive mismatches drop lock; narrow counter saturates
        forced();
        forced();
        forced();
        settle();
        chk("loss_locked", {31'd0, locked}, 0);
        chk("loss_err", {31'd0, err}, 1);
        chk("loss_cnt", {16'd0, cnt}, 6);
        chk("sat_cnt2", {30'd0, cnt2}, 3);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        chk("clr_cnt", {16'd0, cnt}, 0);
        chk("clr_cnt2", {30'd0, cnt2}, 0);

        good(11);
        settle();
        chk("relock_after_11", {31'd0, locked}, 0);
        good(1);
        settle();
        chk("relock_after_12", {31'd0, locked}, 1);

        forced();
        forced();
        forced();
        settle();
        chk("loss2_locked", {31'd0, locked}, 0);
        chk("loss2_cnt", {16'd0, cnt}, 3);
        good(12);
        settle();
        chk("relock2", {31'd0, locked}, 1);

        // Clear coinciding with a counted error
        gen_bit(b);
        step(1'b0, 1'b1, ~b, 1'b1);
        settle();
        chk("clr_err_pulse", {31'd0, err}, 1);
        chk("clr_err_cnt", {16'd0, cnt}, 0);
        good(6);
        settle();
        chk("post_clr_cnt", {16'd0, cnt}, 2);
        chk("post_clr_locked", {31'd0, locked}, 1);

        // Reset mid-LOCKED
        step(1'b1, 1'b1, 1'b1, 1'b0);
        settle();
        chk("midrst_locked", {31'd0, locked}, 0);
        chk("midrst_cnt", {16'd0, cnt}, 0);

        // Stuck-at-0 and stuck-at-1 lines never lock
        do_reset();
        for (int i = 0; i < 200; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        settle();
        chk("stuck0_locked", {31'd0, locked}, 0);
        chk("stuck0_cnt", {16'd0, cnt}, 0);
        do_reset();
        for (int i = 0; i < 200; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        settle();
        chk("stuck1_locked", {31'd0, locked}, 0);

        // Alternating valid: idle cycles carry a junk bit that must be ignored
        do_reset();
        for (int i = 0; i < 22; i++) begin
            if (i % 2 == 0) good(1);
            else step(1'b0, 1'b0, 1'b1, 1'b0);
        end
        settle();
        chk("toggle_11_valid", {31'd0, locked}, 0);
        good(1);
        settle();
        chk("toggle_12_valid", {31'd0, locked}, 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        settle();
        chk("toggle_idle_locked", {31'd0, locked}, 1);
        chk("toggle_idle_cnt", {16'd0, cnt}, 0);

        repeat (3) @(posedge clk);
        #3;
        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/prbs4_checker.md
# prbs4_checker

Receive-side checker for the 4-bit LFSR pattern generator (feedback bit = lfsr[1] ^ lfsr[3], shifted in at bit 0, reset seed 4'b1111). The block consumes the generator's serial stream one bit per qualified cycle, self-synchronises to it, flags every mismatching bit once locked, and keeps a saturating error count. It sits at the far end of a link or loopback path and is the standard bit-error-rate (BER) monitor for the generator.

## Interface
Parameters:
- LOCK_CNT, 8: consecutive predicted-good bits required in HUNT before declaring lock (legal range 1..255).
- LOSS_CNT, 3: consecutive mismatches in LOCKED before dropping lock (legal range 1..255).
- ERR_W, 16: width of the error counter.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high; sampled on posedge clk only.
- valid_i  input  1  bit_i is meaningful this cycle; no backpressure.
- bit_i  input  1  received stream bit (the generator's newly shifted-in bit, i.e. its lfsr_o[0]).
- clr_i  input  1  synchronous clear of err_cnt_o; does not affect lock.
- locked_o  output  1  checker is synchronised.
- err_o  output  1  one-cycle pulse: the bit accepted on the previous edge mismatched while LOCKED.
- err_cnt_o  output  ERR_W  saturating count of mismatches while LOCKED.

## Operation
- History register sr[3:0]: on each valid_i cycle, sr <= {sr[2:0], bit_i}. sr[0] holds the newest bit, sr[3] the oldest.
- Prediction for the incoming bit: pred = sr[1] ^ sr[3]. A match requires bit_i == pred AND sr != 4'b0000. An all-zero history always counts as a mismatch, so a stuck-at-0 line never locks.
- FSM states:
  - FILL: counts 4 valid bits; no comparison. After the 4th valid bit -> HUNT, with good_cnt = 0.
  - HUNT: on a match, good_cnt++; when good_cnt reaches LOCK_CNT -> LOCKED. On a mismatch, good_cnt = 0 and the state stays HUNT. The history is still updated with the raw bit, which gives self-resynchronisation.
  - LOCKED: on a match, bad_run = 0. On a mismatch, err_o pulses, err_cnt is incremented with saturation at 2^ERR_W-1, and bad_run++. When bad_run reaches LOSS_CNT -> FILL, with all counters except err_cnt cleared.
- Cycles with valid_i = 0: no state, counter or history change; err_o = 0.
- Mismatches in FILL and HUNT are never counted and never pulse err_o.
- clr_i coinciding with a counted error: the clear wins and err_cnt becomes 0. The error is still pulsed on err_o.
- Reset outputs: locked_o = 0, err_o = 0, err_cnt_o = 0. FSM = FILL, sr = 0, fill/good/bad counters = 0.
- Reset asserted mid-operation (any state) returns the block to the reset values above on that edge. reset overrides valid_i and clr_i.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- err_o is high in the cycle after the edge that accepted the failing bit. err_cnt_o reflects that error in the same cycle.
- locked_o rises after the edge that accepts the LOCK_CNT-th consecutive good bit. It falls after the edge that accepts the LOSS_CNT-th consecutive bad bit; err_o is also high in that cycle.
- Minimum lock latency from reset deassertion, with valid_i continuously high: 4 + LOCK_CNT valid bits.
- Reference stream for seed 1111, with period 6: 0,0,1,1,1,1 repeating.

## Structure
- Package prbs4_pkg holds:
  - the state enum (FILL, HUNT, LOCKED);
  - localparam SEED = 4'b1111;
  - function prbs4_next_bit(logic [3:0] h) returning h[1] ^ h[3], shared with the generator.
- Sub-module prbs4_predictor holds the history register and the match logic. Inputs: clk, reset, valid_i, bit_i. Outputs: match and hist_zero. The top level holds the FSM and the counters.

## Test plan
- Generator output fed directly, valid_i tied high: locked_o rises exactly 12 valid bits after reset deassertion (LOCK_CNT = 8). err_cnt_o stays 0 over 1000 bits.
- Lock established, then a single flipped bit: err_o pulses 1 cycle and err_cnt_o = 1. The next up to 3 bits also mismatch because of self-sync propagation; each is counted. Lock drops only if 3 of them are consecutive; the bench must check the exact per-bit result against a model.
- bit_i stuck at 0: locked_o never rises in 200 cycles and err_cnt_o stays 0. bit_i stuck at 1 (history 1111, prediction 0): locked_o also never rises.
- valid_i toggling 1-0-1-0 with generator stepping only on valid: lock after 12 valid bits (24 cycles). Idle cycles change nothing.
- Lock, then 3 consecutive forced mismatches: locked_o falls after the 3rd and err_cnt_o = 3. The block then relocks after 12 further good bits.
- ERR_W = 2 with 5 errors: err_cnt_o saturates at 3. Pulsing clr_i gives 0 on the next cycle. reset asserted mid-LOCKED gives locked_o = 0 and err_cnt_o = 0 on the next cycle.
